// File: rtl/mem_stage.sv
// Memory-access stage: issues data-memory requests, aligns and extends load data,
// flags misaligned/illegal accesses and registers the MEM/WB writeback fields.
module mem_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] mem_alu_result,
   input  logic [WIDTH-1:0] mem_reg_data2,
   input  logic [4:0]       mem_rd,
   input  logic [2:0]       mem_funct3,
   input  logic [6:0]       mem_opcode,
   input  logic             mem_reg_wr_en,
   input  logic             mem_mem_to_reg,
   input  logic [1:0]       mem_wb_sel,
   input  logic [WIDTH-1:0] mem_pc_plus4,
   input  logic             mem_mem_wr_en,
   output logic             dmem_req_valid,
   input  logic             dmem_req_ready,
   output logic [WIDTH-1:0] dmem_req_addr,
   output logic             dmem_req_we,
   output logic [WIDTH-1:0] dmem_req_wdata,
   output logic [3:0]       dmem_req_be,
   input  logic             dmem_rsp_valid,
   input  logic [WIDTH-1:0] dmem_rsp_rdata,
   output logic             stall_req,
   output logic [WIDTH-1:0] wb_result,
   output logic [4:0]       wb_rd,
   output logic             wb_reg_wr_en,
   output logic             wb_mem_to_reg,
   output logic             mem_exc,
   output logic [WIDTH-1:0] mem_exc_addr
);

   localparam logic [6:0] OP_LOAD = 7'b0000011;

   typedef enum logic [1:0] {IDLE, WAIT_RSP, DONE} state_t;

   state_t           state;
   logic             is_load, is_store, is_mem;
   logic             misaligned, illegal, fault, mem_go;
   logic [1:0]       off;
   logic [15:0]      lane;
   logic [WIDTH-1:0] load_ext, load_data, wb_next;

   // Access classification and fault detection
   always_comb begin
      is_load    = (mem_opcode == OP_LOAD);
      is_store   = mem_mem_wr_en;
      is_mem     = is_load || is_store;
      off        = mem_alu_result[1:0];
      misaligned = ((mem_funct3[1:0] == 2'b01) && off[0]) ||
                   ((mem_funct3[1:0] == 2'b10) && (off != 2'b00));
      if (is_store)
         illegal = (mem_funct3 > 3'b010);
      else
         illegal = (mem_funct3 == 3'b011) || (mem_funct3[2:1] == 2'b11);
      fault  = is_mem && (misaligned || illegal);
      mem_go = is_mem && !fault;
   end

   // Stall depends only on state and the EX/MEM instruction
   assign dmem_req_valid = (state == IDLE) && mem_go;
   assign stall_req      = dmem_req_valid || (state == WAIT_RSP);
   assign dmem_req_addr  = {mem_alu_result[WIDTH-1:2], 2'b00};
   assign dmem_req_we    = is_store;

   always_comb begin
      dmem_req_wdata = mem_reg_data2;
      dmem_req_be    = 4'b1111;
      case (mem_funct3[1:0])
         2'b00: begin
            dmem_req_wdata = {4{mem_reg_data2[7:0]}};
            dmem_req_be    = 4'b0001 << off;
         end
         2'b01: begin
            dmem_req_wdata = {2{mem_reg_data2[15:0]}};
            dmem_req_be    = 4'b0011 << off;
         end
         default: ;
      endcase
   end

   // Load lane extraction and sign/zero extension
   always_comb begin
      lane     = 16'(dmem_rsp_rdata >> {off, 3'b000});
      load_ext = dmem_rsp_rdata;
      case (mem_funct3)
         3'b000:  load_ext = {{(WIDTH-8){lane[7]}}, lane[7:0]};
         3'b100:  load_ext = {{(WIDTH-8){1'b0}}, lane[7:0]};
         3'b001:  load_ext = {{(WIDTH-16){lane[15]}}, lane};
         3'b101:  load_ext = {{(WIDTH-16){1'b0}}, lane};
         default: ;
      endcase
   end

   always_comb begin
      case (mem_wb_sel)
         2'b01:   wb_next = load_data;
         2'b10:   wb_next = mem_pc_plus4;
         default: wb_next = mem_alu_result;
      endcase
   end

   // Access FSM and load-response latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         load_data <= '0;
      end else begin
         case (state)
            IDLE:
               if (mem_go && dmem_req_ready)
                  state <= is_store ? DONE : WAIT_RSP;
            WAIT_RSP:
               if (dmem_rsp_valid) begin
                  load_data <= load_ext;
                  state     <= DONE;
               end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // MEM/WB register; a stall inserts a bubble by dropping the write enable
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_result     <= '0;
         wb_rd         <= '0;
         wb_reg_wr_en  <= 1'b0;
         wb_mem_to_reg <= 1'b0;
         mem_exc       <= 1'b0;
         mem_exc_addr  <= '0;
      end else begin
         mem_exc <= 1'b0;
         if (stall_req) begin
            wb_reg_wr_en <= 1'b0;
         end else begin
            wb_result     <= wb_next;
            wb_rd         <= mem_rd;
            wb_mem_to_reg <= mem_mem_to_reg;
            wb_reg_wr_en  <= mem_reg_wr_en && !fault;
            if (fault) begin
               mem_exc      <= 1'b1;
               mem_exc_addr <= mem_alu_result;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus random instruction stream
// checked against a behavioural model of alignment, extension and timing.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_alu_result = '0, mem_reg_data2 = '0, mem_pc_plus4 = '0;
   logic [4:0]  mem_rd = '0;
   logic [2:0]  mem_funct3 = '0;
   logic [6:0]  mem_opcode = '0;
   logic        mem_reg_wr_en = 1'b0, mem_mem_to_reg = 1'b0, mem_mem_wr_en = 1'b0;
   logic [1:0]  mem_wb_sel = '0;
   logic        dmem_req_valid, dmem_req_we, stall_req;
   logic        dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
   logic [31:0] dmem_req_addr, dmem_req_wdata, dmem_rsp_rdata = '0;
   logic [3:0]  dmem_req_be;
   logic [31:0] wb_result, mem_exc_addr;
   logic [4:0]  wb_rd;
   logic        wb_reg_wr_en, wb_mem_to_reg, mem_exc;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m_last_load = '0;
   logic [31:0] m_exc_addr  = '0;
   logic [31:0] seen_addr, seen_wdata;
   logic [3:0]  seen_be;
   logic        seen_we;
   int          seen_stalls;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   mem_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .mem_alu_result(mem_alu_result), .mem_reg_data2(mem_reg_data2),
      .mem_rd(mem_rd), .mem_funct3(mem_funct3), .mem_opcode(mem_opcode),
      .mem_reg_wr_en(mem_reg_wr_en), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_wb_sel(mem_wb_sel), .mem_pc_plus4(mem_pc_plus4),
      .mem_mem_wr_en(mem_mem_wr_en),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
      .dmem_req_addr(dmem_req_addr), .dmem_req_we(dmem_req_we),
      .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
      .stall_req(stall_req), .wb_result(wb_result), .wb_rd(wb_rd),
      .wb_reg_wr_en(wb_reg_wr_en), .wb_mem_to_reg(wb_mem_to_reg),
      .mem_exc(mem_exc), .mem_exc_addr(mem_exc_addr)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
      logic [31:0] w, v;
      w = rdata >> (8 * (addr % 4));
      case (f3)
         3'd0: begin v = w & 32'hFF;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
         3'd4: v = w & 32'hFF;
         3'd1: begin v = w & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF_0000; end
         3'd5: v = w & 32'hFFFF;
         default: v = rdata;
      endcase
      return v;
   endfunction

   // Runs one instruction through the stage acting as pipeline and memory; call at a negedge.
   task automatic exec(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [31:0] pc4, input logic [4:0] rd,
                       input logic [1:0] sel, input logic rwe, input logic m2r, input logic mwe,
                       input int rwait, input int rdly, input logic [31:0] rdata,
                       input string tag);
      logic is_ld, memop, ill, flt, go, acc, done, v_s;
      logic [31:0] ex_wd, ex_res;
      logic [3:0]  ex_be;
      int c, acc_c, exp_stall, nb;
      mem_opcode = op; mem_funct3 = f3; mem_alu_result = addr; mem_reg_data2 = rs2;
      mem_pc_plus4 = pc4; mem_rd = rd; mem_wb_sel = sel; mem_reg_wr_en = rwe;
      mem_mem_to_reg = m2r; mem_mem_wr_en = mwe;
      is_ld = (op == OP_LOAD);
      memop = is_ld || mwe;
      ill   = mwe ? (f3 > 3'd2) : (f3 inside {3'd3, 3'd6, 3'd7});
      nb    = 1 << f3[1:0];
      flt   = memop && (ill || (addr % nb) != 0);
      go    = memop && !flt;
      exp_stall = !go ? 0 : (mwe ? rwait + 1 : rwait + rdly + 1);
      case (f3[1:0])
         2'd0:    begin ex_wd = (rs2 & 32'hFF) * 32'h0101_0101;   ex_be = 4'(1 << (addr % 4)); end
         2'd1:    begin ex_wd = (rs2 & 32'hFFFF) * 32'h0001_0001; ex_be = 4'(3 << (addr % 4)); end
         default: begin ex_wd = rs2; ex_be = 4'hF; end
      endcase
      c = 0; acc = 0; acc_c = 0; done = 0; seen_stalls = 0;
      while (!done && c < 60) begin
         dmem_req_ready = (c >= rwait) && !acc;
         if (go && is_ld && !mwe) begin
            dmem_rsp_valid = acc && (c - acc_c == rdly);
            dmem_rsp_rdata = dmem_rsp_valid ? rdata : $urandom;
         end else begin
            dmem_rsp_valid = 1'($urandom % 2);
            dmem_rsp_rdata = $urandom;
         end
         #1;
         v_s = dmem_req_valid;
         n_cmp++;
         if (dmem_req_valid !== (go && !acc)) begin
            n_err++;
            $display("FAIL %s req_valid cyc %0d got %b exp %b", tag, c, dmem_req_valid, go && !acc);
         end
         if (v_s) begin
            n_cmp++;
            if (dmem_req_addr !== (addr & ~32'h3) || dmem_req_we !== mwe) begin
               n_err++;
               $display("FAIL %s req addr/we got %h/%b exp %h/%b", tag, dmem_req_addr,
                        dmem_req_we, addr & ~32'h3, mwe);
            end
            if (mwe) begin
               n_cmp++;
               if (dmem_req_wdata !== ex_wd || dmem_req_be !== ex_be) begin
                  n_err++;
                  $display("FAIL %s req wdata/be got %h/%b exp %h/%b", tag, dmem_req_wdata,
                           dmem_req_be, ex_wd, ex_be);
               end
            end
            seen_addr = dmem_req_addr; seen_wdata = dmem_req_wdata;
            seen_be = dmem_req_be; seen_we = dmem_req_we;
         end
         if (stall_req && c >= 1) begin
            n_cmp++;
            if (wb_reg_wr_en !== 1'b0) begin
               n_err++;
               $display("FAIL %s bubble wb_reg_wr_en got %b exp 0", tag, wb_reg_wr_en);
            end
         end
         if (stall_req === 1'b1) seen_stalls++;
         else done = 1;
         @(posedge clk);
         if (v_s && dmem_req_ready && !acc) begin acc = 1; acc_c = c; end
         c++;
         @(negedge clk);
      end
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
      n_cmp++;
      if (!done || seen_stalls != exp_stall) begin
         n_err++;
         $display("FAIL %s stall cycles got %0d exp %0d (done=%b)", tag, seen_stalls, exp_stall, done);
      end
      if (go && is_ld && !mwe) m_last_load = ld_model(f3, addr, rdata);
      if (flt) m_exc_addr = addr;
      case (sel)
         2'd1:    ex_res = m_last_load;
         2'd2:    ex_res = pc4;
         default: ex_res = addr;
      endcase
      #1;
      n_cmp++;
      if (wb_result !== ex_res || wb_rd !== rd || wb_mem_to_reg !== m2r) begin
         n_err++;
         $display("FAIL %s wb result/rd/m2r got %h/%0d/%b exp %h/%0d/%b", tag, wb_result, wb_rd,
                  wb_mem_to_reg, ex_res, rd, m2r);
      end
      n_cmp++;
      if (wb_reg_wr_en !== (rwe && !flt)) begin
         n_err++;
         $display("FAIL %s wb_reg_wr_en got %b exp %b", tag, wb_reg_wr_en, rwe && !flt);
      end
      n_cmp++;
      if (mem_exc !== flt || mem_exc_addr !== m_exc_addr) begin
         n_err++;
         $display("FAIL %s exc/addr got %b/%h exp %b/%h", tag, mem_exc, mem_exc_addr, flt, m_exc_addr);
      end
   endtask

   task automatic nop(input string tag);
      exec(OP_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 0, 1, 32'h0, tag);
   endtask

   task automatic test_reset;
      #1;
      n_cmp++;
      if (stall_req !== 1'b0 || dmem_req_valid !== 1'b0 || wb_result !== 32'h0 || wb_rd !== 5'd0 ||
          wb_reg_wr_en !== 1'b0 || wb_mem_to_reg !== 1'b0 || mem_exc !== 1'b0 || mem_exc_addr !== 32'h0) begin
         n_err++;
         $display("FAIL reset outputs got stall=%b v=%b res=%h rd=%0d we=%b exc=%b ea=%h exp all 0",
                  stall_req, dmem_req_valid, wb_result, wb_rd, wb_reg_wr_en, mem_exc, mem_exc_addr);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_alu;
      exec(OP_ALU, 3'd0, 32'h1234, 32'h0, 32'h0, 5'd3, 2'd0, 1'b1, 1'b0, 1'b0, 0, 1, 32'h0, "add");
      n_cmp++;
      if (wb_result !== 32'h1234 || seen_stalls != 0) begin
         n_err++;
         $display("FAIL add literal got %h stalls %0d exp 00001234 stalls 0", wb_result, seen_stalls);
      end
   endtask

   task automatic test_load_byte;
      exec(OP_LOAD, 3'd0, 32'h103, 32'h0, 32'h0, 5'd5, 2'd1, 1'b1, 1'b1, 1'b0, 2, 1, 32'h80FF_EE11, "lb");
      n_cmp++;
      if (wb_result !== 32'hFFFF_FF80 || seen_addr !== 32'h100 || seen_stalls != 4) begin
         n_err++;
         $display("FAIL lb literal got %h addr %h stalls %0d exp ffffff80 00000100 4",
                  wb_result, seen_addr, seen_stalls);
      end
      exec(OP_LOAD, 3'd4, 32'h103, 32'h0, 32'h0, 5'd6, 2'd1, 1'b1, 1'b1, 1'b0, 2, 1, 32'h80FF_EE11, "lbu");
      n_cmp++;
      if (wb_result !== 32'h0000_0080) begin
         n_err++;
         $display("FAIL lbu literal got %h exp 00000080", wb_result);
      end
   endtask

   task automatic test_store_half;
      exec(OP_STORE, 3'd1, 32'h202, 32'hAAAA_BEEF, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 1, 32'h0, "sh");
      n_cmp++;
      if (seen_wdata !== 32'hBEEF_BEEF || seen_be !== 4'b1100 || seen_we !== 1'b1 || seen_stalls != 1) begin
         n_err++;
         $display("FAIL sh literal got %h/%b/%b stalls %0d exp beefbeef/1100/1 stalls 1",
                  seen_wdata, seen_be, seen_we, seen_stalls);
      end
   endtask

   task automatic test_misaligned;
      exec(OP_LOAD, 3'd2, 32'h6, 32'h0, 32'h0, 5'd7, 2'd1, 1'b1, 1'b1, 1'b0, 0, 1, 32'h0, "lw_mis");
      n_cmp++;
      if (mem_exc !== 1'b1 || mem_exc_addr !== 32'h6 || wb_reg_wr_en !== 1'b0) begin
         n_err++;
         $display("FAIL lw_mis literal got exc=%b ea=%h we=%b exp 1/00000006/0", mem_exc, mem_exc_addr, wb_reg_wr_en);
      end
      nop("after_exc");
   endtask

   task automatic test_back_to_back;
      exec(OP_JAL, 3'd0, 32'h999, 32'h0, 32'h48, 5'd1, 2'd2, 1'b1, 1'b0, 1'b0, 0, 1, 32'h0, "jal");
      n_cmp++;
      if (wb_result !== 32'h48) begin
         n_err++;
         $display("FAIL jal literal got %h exp 00000048", wb_result);
      end
      exec(OP_LOAD, 3'd2, 32'h40, 32'h0, 32'h0, 5'd8, 2'd1, 1'b1, 1'b1, 1'b0, 0, 1, 32'hCAFE_F00D, "b2b_lw");
      exec(OP_STORE, 3'd2, 32'h44, 32'h1357_9BDF, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 0, 1, 32'h0, "b2b_sw");
   endtask

   task automatic test_reset_mid_access;
      mem_opcode = OP_LOAD; mem_funct3 = 3'd2; mem_alu_result = 32'h80; mem_rd = 5'd9;
      mem_wb_sel = 2'd1; mem_reg_wr_en = 1'b1; mem_mem_to_reg = 1'b1; mem_mem_wr_en = 1'b0;
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      #1;
      n_cmp++;
      if (stall_req !== 1'b1 || dmem_req_valid !== 1'b0) begin
         n_err++;
         $display("FAIL wait_rsp stall/valid got %b/%b exp 1/0", stall_req, dmem_req_valid);
      end
      rst = 1'b1;
      mem_opcode = '0; mem_funct3 = '0; mem_alu_result = '0; mem_rd = '0; mem_wb_sel = '0;
      mem_reg_wr_en = 1'b0; mem_mem_to_reg = 1'b0;
      dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 32'hDEAD_BEEF;
      #1;
      n_cmp++;
      if (stall_req !== 1'b0 || dmem_req_valid !== 1'b0 || wb_result !== 32'h0 || wb_reg_wr_en !== 1'b0 ||
          mem_exc !== 1'b0 || mem_exc_addr !== 32'h0) begin
         n_err++;
         $display("FAIL mid_rst outputs got stall=%b v=%b res=%h we=%b exc=%b ea=%h exp all 0",
                  stall_req, dmem_req_valid, wb_result, wb_reg_wr_en, mem_exc, mem_exc_addr);
      end
      @(negedge clk); rst = 1'b0;
      m_last_load = '0; m_exc_addr = '0;
      @(negedge clk); dmem_rsp_valid = 1'b0;
      exec(OP_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 5'd4, 2'd1, 1'b1, 1'b0, 1'b0, 0, 1, 32'h0, "stale_rsp");
      n_cmp++;
      if (wb_result !== 32'h0) begin
         n_err++;
         $display("FAIL stale_rsp literal got %h exp 00000000", wb_result);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 60; i++) begin
         logic [31:0] a;
         int          t;
         a = $urandom & 32'h0000_FFFF;
         if ($urandom % 2 == 1) a = a & ~32'h3;
         t = int'($urandom % 4);
         case (t)
            0: exec(OP_ALU, 3'($urandom), a, $urandom, $urandom, 5'($urandom), 2'($urandom), 1'b1,
                    1'b0, 1'b0, 0, 1, 32'h0, "rnd_alu");
            1: exec(OP_LOAD, 3'($urandom), a, $urandom, $urandom, 5'($urandom), 2'd1, 1'b1, 1'b1,
                    1'b0, int'($urandom % 4), int'($urandom % 3) + 1, $urandom, "rnd_ld");
            2: exec(OP_STORE, 3'($urandom % 4), a, $urandom, $urandom, 5'($urandom), 2'd0, 1'b0,
                    1'b0, 1'b1, int'($urandom % 4), 1, 32'h0, "rnd_st");
            default: exec(OP_JAL, 3'd0, a, $urandom, $urandom, 5'($urandom), 2'd2, 1'b1, 1'b0,
                          1'b0, 0, 1, 32'h0, "rnd_jal");
         endcase
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_byte();
      test_store_half();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
